// File: rtl/adc_decimator.sv
// Boxcar decimator for a signed ADC sample stream: averages 2^D samples and
// queues results in a small FIFO with valid/ready output and drop counting.
module adc_decimator #(
  parameter int DATA_W     = 16,
  parameter int MAX_LOG2   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int OVF_W      = 16
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [3:0]          decim_log2,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          fifo_level,
  output logic [OVF_W-1:0]    overflow_cnt,
  input  logic                clear_overflow
);

  localparam int ACC_W = DATA_W + MAX_LOG2;
  localparam int D_W   = $clog2(MAX_LOG2 + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ACCUM = 1'b1;

  logic                     state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [MAX_LOG2-1:0]      cnt_q, cnt_d;
  logic [D_W-1:0]           dlat_q, dlat_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [OVF_W-1:0]         ovf_q, ovf_d;
  logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];

  logic                     accept;
  logic [MAX_LOG2-1:0]      cnt_eff;
  logic [D_W-1:0]           d_clamped;
  logic [D_W-1:0]           d_use;
  logic [MAX_LOG2:0]        last_idx;
  logic                     block_done;
  logic signed [ACC_W-1:0]  sum;
  logic [DATA_W-1:0]        push_data;
  logic                     push_req;
  logic                     pop;
  logic                     full;
  logic                     push_ok;
  logic                     overflow;

  assign accept = enable && in_valid;

  // A count carried over from a previous ACCUM interval is never reused.
  assign cnt_eff = (state_q == ST_ACCUM) ? cnt_q : '0;

  always_comb begin
    d_clamped = (decim_log2 > 4'(MAX_LOG2)) ? D_W'(MAX_LOG2) : D_W'(decim_log2);
    d_use     = (cnt_eff == '0) ? d_clamped : dlat_q;
    last_idx  = ((MAX_LOG2+1)'(1) << d_use) - (MAX_LOG2+1)'(1);
    block_done = ({1'b0, cnt_eff} == last_idx);
    sum = ((cnt_eff == '0) ? ACC_W'(0) : acc_q)
          + $signed({{MAX_LOG2{in_data[DATA_W-1]}}, in_data});
    push_data = DATA_W'(sum >>> d_use);
    push_req  = accept && block_done;
  end

  always_comb begin
    state_d = enable ? ST_ACCUM : ST_IDLE;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      if (cnt_eff == '0) dlat_d = d_clamped;
      if (block_done) begin
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_eff + MAX_LOG2'(1);
      end
    end
  end

  // FIFO: a pop frees the slot a same-cycle push needs, even when full.
  always_comb begin
    pop      = (level_q != '0) && out_ready;
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    push_ok  = push_req && (!full || pop);
    overflow = push_req && full && !pop;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push_ok) - LVL_W'(pop);

    out_data_d = out_data_q;
    if (level_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d))
        out_data_d = push_data;
      else
        out_data_d = mem_q[rd_ptr_d];
    end

    ovf_d = ovf_q;
    if (clear_overflow)
      ovf_d = '0;
    else if (overflow && (ovf_q != '1))
      ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      dlat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      dlat_q     <= dlat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_data     = out_data_q;
  assign out_valid    = (level_q != '0);
  assign fifo_level   = 3'(level_q);
  assign overflow_cnt = ovf_q;

endmodule

// File: doc/adc_decimator.md
Name: adc_decimator

Overview:
Downstream consumer of the 16-bit ADC sample stream that the LTC2387 serial interface delivers in the sys_clk domain. The block boxcar-averages 2^D consecutive two's-complement samples, with D selectable at run time from 0 to 8. Averaged results are buffered in a 4-entry FIFO with a valid/ready output toward the capture/DMA logic. Samples that cannot be buffered are dropped and counted.

Parameters:
DATA_W, 16, sample and output width (signed two's complement)
MAX_LOG2, 8, maximum decimation exponent; accumulator width is DATA_W+MAX_LOG2
FIFO_DEPTH, 4, output FIFO entries (power of two)
OVF_W, 16, overflow counter width

Ports:
sys_clk  input  1  system clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  high = accumulate; low = discard input and flush the partial block
decim_log2  input  4  decimation exponent D; values above MAX_LOG2 clamp to MAX_LOG2
in_data  input  DATA_W  ADC sample, signed
in_valid  input  1  sample strobe, single-cycle pulse per sample
out_data  output  DATA_W  FIFO head, the averaged sample
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts head when out_valid and out_ready are both high
fifo_level  output 3  number of occupied entries, 0..4
overflow_cnt  output  OVF_W  count of dropped results, saturating
clear_overflow  input  1  synchronous clear of overflow_cnt

Behaviour:
- Reset (async assert, sync-released by sys_clk): acc=0, cnt=0, latched D=0, FIFO empty.
- Outputs in reset: out_data=0, out_valid=0, fifo_level=0, overflow_cnt=0.
- States:
  - IDLE (enable low): in_valid is ignored; cnt and acc are cleared each cycle.
  - ACCUM (enable high).
  - IDLE->ACCUM on enable rising; ACCUM->IDLE on enable falling.
  - On leaving ACCUM, the partial block is discarded and nothing is pushed.
  - FIFO contents remain drainable in both states.
- D latch: D_eff = min(decim_log2, MAX_LOG2) is captured when a sample is accepted with cnt==0. Changes to decim_log2 mid-block take effect at the next block.
- Accumulation, on in_valid in ACCUM:
  - sum = (cnt==0 ? 0 : acc) + sext(in_data), computed at the accumulator width.
  - If cnt == 2^D_eff - 1: result = sum >>> D_eff (arithmetic shift, truncation toward -inf), low DATA_W bits pushed; cnt<=0.
  - Otherwise: acc<=sum; cnt<=cnt+1.
  - D_eff=0 means every sample passes through unchanged.
- Latency: result is written at the edge that accepts the final sample of the block. out_valid rises on the next cycle if the FIFO was empty. out_data shows the oldest entry (registered read, no bubble).
- FIFO:
  - Pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle are both performed, including when full; level is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - Push when level==4 without a same-cycle pop drops the new result; FIFO is unchanged and overflow_cnt increments.
  - overflow_cnt saturates at 2^OVF_W-1.
  - clear_overflow sets the counter to 0; clear wins over a same-cycle overflow.
- in_valid on consecutive cycles is supported at one sample per clock. No input backpressure exists.
- Reset mid-block or mid-drain: all state is lost immediately and outputs return to reset values.

Test Plan:
- D=0, enable=1, samples 0x1234, 0x8000, 0x7FFF with out_ready=1 -> outputs identical, each one cycle after its in_valid; fifo_level never exceeds 1.
- D=2, samples 4, 5, 6, 7 -> single output 0x0005 (22>>>2). Samples -1, -2, -2, -2 -> 0xFFFE (-7>>>2 = -2).
- D=8, 256 samples of 0x7FFF -> output 0x7FFF with no accumulator wrap. 256 samples of 0x8000 -> 0x8000.
- D=0, out_ready=0, 6 samples 1..6 -> fifo_level=4, overflow_cnt=2, drained order 1,2,3,4. Then clear_overflow together with a 7th overflow -> overflow_cnt=0.
- D=2, 2 samples then enable low for 1 cycle, then 4 samples of 8 -> exactly one output 0x0008. Changing decim_log2 2->1 after sample 1 -> current block still uses 4 samples, next block uses 2.
- Level=4 and out_ready=1 with a push in the same cycle -> level stays 4, no overflow, new result at the tail. Reset asserted mid-block -> out_valid=0 and fifo_level=0 asynchronously.
